// File: rtl/ov7670_fake.sv
// Free-running OV7670 camera look-alike: generates href/hsync/vsync timing and a
// deterministic byte ramp on camData, all launched on the falling edge of pclk.
module ov7670_fake #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_TOTAL     = 1568,
  parameter int HS_START    = 1312,
  parameter int HS_WIDTH    = 160,
  parameter int V_TOTAL     = 510,
  parameter int VS_LINES    = 3,
  parameter int V_ACT_START = 20,
  parameter int V_ACTIVE    = 480
) (
  input  logic       pclk,
  input  logic       reset,
  output logic       href,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] camData
);

  localparam int CW = $clog2(H_TOTAL);
  localparam int LW = $clog2(V_TOTAL);
  localparam logic [CW-1:0] COL_LAST  = CW'(H_TOTAL - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_TOTAL - 1);

  logic [CW-1:0] col_cnt;
  logic [LW-1:0] line_cnt;
  logic [7:0]    frame_cnt;

  logic       href_nx;
  logic       hsync_nx;
  logic       vsync_nx;
  logic [7:0] data_nx;

  always_comb begin
    href_nx  = (int'(line_cnt) >= V_ACT_START) &&
               (int'(line_cnt) <  V_ACT_START + V_ACTIVE) &&
               (int'(col_cnt)  <  H_ACTIVE);
    hsync_nx = (int'(col_cnt) >= HS_START) && (int'(col_cnt) < HS_START + HS_WIDTH);
    vsync_nx = (int'(line_cnt) < VS_LINES);
    // Ramp is relative to the first active line so every frame's top line starts at the frame number.
    data_nx  = 8'h00;
    if (href_nx)
      data_nx = 8'(col_cnt) + 8'(line_cnt) - 8'(V_ACT_START) + frame_cnt;
  end

  // Falling-edge launch keeps every output stable across the consumer's rising edge.
  always_ff @(negedge pclk or negedge reset) begin
    if (!reset) begin
      col_cnt   <= '0;
      line_cnt  <= '0;
      frame_cnt <= '0;
      href      <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      camData   <= 8'h00;
    end else begin
      href    <= href_nx;
      hsync   <= hsync_nx;
      vsync   <= vsync_nx;
      camData <= data_nx;
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        if (line_cnt == LINE_LAST) begin
          line_cnt  <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          line_cnt <= line_cnt + 1'b1;
        end
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_fake.sv
// Directed bench for ov7670_fake: one default-timing instance and one small-timing
// instance share pclk; outputs are sampled on the rising edge.
module tb_ov7670_fake;

  logic       pclk;
  logic       rst_d;
  logic       rst_s;
  logic       href_d, hsync_d, vsync_d;
  logic [7:0] data_d;
  logic       href_s, hsync_s, vsync_s;
  logic [7:0] data_s;

  int n_checks = 0;
  int n_err    = 0;

  ov7670_fake dut_def (
    .pclk    (pclk),
    .reset   (rst_d),
    .href    (href_d),
    .hsync   (hsync_d),
    .vsync   (vsync_d),
    .camData (data_d)
  );

  ov7670_fake #(
    .H_ACTIVE    (8),
    .H_TOTAL     (16),
    .HS_START    (10),
    .HS_WIDTH    (2),
    .V_TOTAL     (8),
    .VS_LINES    (1),
    .V_ACT_START (2),
    .V_ACTIVE    (4)
  ) dut_small (
    .pclk    (pclk),
    .reset   (rst_s),
    .href    (href_s),
    .hsync   (hsync_s),
    .vsync   (vsync_s),
    .camData (data_s)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next output update and sample it on the following rising edge.
  task automatic step();
    @(negedge pclk);
    @(posedge pclk);
  endtask

  initial begin
    int   vs_cnt, href_len, excl_viol, href_s_cnt, href_s_rises;
    logic href_s_prev, vs_prev, found;

    vs_cnt = 0; href_len = 0; excl_viol = 0; href_s_cnt = 0; href_s_rises = 0;
    href_s_prev = 1'b0;

    rst_d = 1'b1;
    rst_s = 1'b1;
    #1;
    rst_d = 1'b0;
    rst_s = 1'b0;
    repeat (3) @(posedge pclk);
    check("rst_href_d",  {31'd0, href_d},  0);
    check("rst_hsync_d", {31'd0, hsync_d}, 0);
    check("rst_vsync_d", {31'd0, vsync_d}, 0);
    check("rst_data_d",  {24'd0, data_d},  0);
    check("rst_vsync_s", {31'd0, vsync_s}, 0);
    rst_d = 1'b1;
    rst_s = 1'b1;

    for (int k = 0; k <= 32680; k++) begin
      step();
      if (vsync_d && href_d) excl_viol++;
      if (k < 31360 && vsync_d) vs_cnt++;
      if (k >= 31360 && k < 32640 && href_d) href_len++;
      if (k < 128) begin
        if (href_s) href_s_cnt++;
        if (href_s && !href_s_prev) href_s_rises++;
      end
      href_s_prev = href_s;
      case (k)
        0: begin
          check("first_vsync_d", {31'd0, vsync_d}, 1);
          check("first_href_d",  {31'd0, href_d},  0);
          check("first_hsync_d", {31'd0, hsync_d}, 0);
          check("first_data_d",  {24'd0, data_d},  0);
          check("first_vsync_s", {31'd0, vsync_s}, 1);
          check("first_href_s",  {31'd0, href_s},  0);
        end
        10:    begin check("s_hs_on", {31'd0, hsync_s}, 1); check("s_vs_with_hs", {31'd0, vsync_s}, 1); end
        12:    check("s_hs_off", {31'd0, hsync_s}, 0);
        15:    check("s_vs_line0_end", {31'd0, vsync_s}, 1);
        16:    check("s_vs_off", {31'd0, vsync_s}, 0);
        32:    begin check("s_href_on", {31'd0, href_s}, 1); check("s_data_l2c0", {24'd0, data_s}, 0); end
        39:    check("s_data_l2c7", {24'd0, data_s}, 7);
        40:    begin check("s_href_off", {31'd0, href_s}, 0); check("s_data_blank", {24'd0, data_s}, 0); end
        87:    check("s_data_l5c7", {24'd0, data_s}, 10);
        96:    check("s_href_l6", {31'd0, href_s}, 0);
        128:   check("s_vs_frame1", {31'd0, vsync_s}, 1);
        160:   begin check("s_href_f1", {31'd0, href_s}, 1); check("s_data_f1_c0", {24'd0, data_s}, 1); end
        167:   check("s_data_f1_c7", {24'd0, data_s}, 8);
        1279:  check("d_href_blank_line", {31'd0, href_d}, 0);
        1311:  check("d_hs_before", {31'd0, hsync_d}, 0);
        1312:  begin check("d_hs_on", {31'd0, hsync_d}, 1); check("d_vs_with_hs", {31'd0, vsync_d}, 1); end
        1471:  check("d_hs_last", {31'd0, hsync_d}, 1);
        1472:  check("d_hs_off", {31'd0, hsync_d}, 0);
        4703:  check("d_vs_last", {31'd0, vsync_d}, 1);
        4704:  check("d_vs_off", {31'd0, vsync_d}, 0);
        31359: check("d_href_l19", {31'd0, href_d}, 0);
        31360: begin check("d_href_l20", {31'd0, href_d}, 1); check("d_data_c0", {24'd0, data_d}, 0); end
        31361: check("d_data_c1", {24'd0, data_d}, 1);
        31615: check("d_data_c255", {24'd0, data_d}, 255);
        31616: check("d_data_c256", {24'd0, data_d}, 0);
        32639: begin check("d_href_c1279", {31'd0, href_d}, 1); check("d_data_c1279", {24'd0, data_d}, 255); end
        32640: begin check("d_href_c1280", {31'd0, href_d}, 0); check("d_data_blank", {24'd0, data_d}, 0); end
        32672: begin check("d_hs_active_line", {31'd0, hsync_d}, 1); check("d_href_at_hs", {31'd0, href_d}, 0); end
        default: ;
      endcase
    end
    check("d_vs_cycles",    vs_cnt,    4704);
    check("d_href_len",     href_len,  1280);
    check("d_vs_href_excl", excl_viol, 0);
    check("s_href_cycles",  href_s_cnt, 32);
    check("s_href_pulses",  href_s_rises, 4);

    // Align to a small-instance frame start, then reset it in the middle of line 5.
    found   = 1'b0;
    vs_prev = vsync_s;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (vsync_s && !vs_prev) found = 1'b1;
      vs_prev = vsync_s;
    end
    check("s_vs_rise_seen", {31'd0, found}, 1);
    repeat (83) step();
    check("s_href_pre_rst", {31'd0, href_s}, 1);
    #2;
    rst_s = 1'b0;
    #1;
    check("s_rst_href",  {31'd0, href_s},  0);
    check("s_rst_hsync", {31'd0, hsync_s}, 0);
    check("s_rst_vsync", {31'd0, vsync_s}, 0);
    check("s_rst_data",  {24'd0, data_s},  0);
    repeat (3) @(posedge pclk);
    check("s_rst_hold_href", {31'd0, href_s}, 0);
    check("s_rst_hold_data", {24'd0, data_s}, 0);
    rst_s = 1'b1;

    vs_cnt = 0;
    for (int k = 0; k <= 32; k++) begin
      step();
      if (k < 16 && vsync_s) vs_cnt++;
      case (k)
        0:  check("s_post_href", {31'd0, href_s}, 0);
        16: check("s_post_vs_off", {31'd0, vsync_s}, 0);
        32: begin check("s_post_href_l2", {31'd0, href_s}, 1); check("s_post_data", {24'd0, data_s}, 0); end
        default: ;
      endcase
    end
    check("s_post_vs_cycles", vs_cnt, 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ov7670_fake.md
OV7670_FAKE -- requirements
Module: ov7670_fake

Interface
Parameters:
REQ-001 SHALL provide parameter H_ACTIVE, default 1280, href-high pclk cycles per active line (640 px x 2 bytes).
REQ-002 SHALL provide parameter H_TOTAL, default 1568, pclk cycles per line (784 tP x 2).
REQ-003 SHALL provide parameter HS_START, default 1312, line cycle index where hsync rises.
REQ-004 SHALL provide parameter HS_WIDTH, default 160, hsync high duration in pclk cycles.
REQ-005 SHALL provide parameter V_TOTAL, default 510, lines per frame.
REQ-006 SHALL provide parameter VS_LINES, default 3, lines with vsync high at frame start.
REQ-007 SHALL provide parameter V_ACT_START, default 20, first active line index.
REQ-008 SHALL provide parameter V_ACTIVE, default 480, number of active lines.

Ports:
REQ-009 pclk  input  1  pixel clock, the block's only clock.
REQ-010 reset  input  1  asynchronous, active-low reset.
REQ-011 href  output  1  high while camData carries valid pixel bytes.
REQ-012 hsync  output  1  active-high horizontal sync pulse.
REQ-013 vsync  output  1  active-high vertical sync, frame start.
REQ-014 camData  output  8  pixel byte stream.

Function
REQ-015 SHALL keep col counter 0..H_TOTAL-1, incrementing every pclk cycle and wrapping to 0.
REQ-016 SHALL keep line counter 0..V_TOTAL-1, incrementing when col wraps; wrapping to 0 after V_TOTAL-1.
REQ-017 SHALL keep an 8-bit frame counter, incrementing when line and col both wrap, modulo 256.
REQ-018 SHALL update all outputs and counters on the falling edge of pclk, so outputs are stable at every rising edge.
REQ-019 SHALL drive every output from a register, glitch-free, decoded from the current counter values.
REQ-020 href SHALL be 1 iff V_ACT_START <= line < V_ACT_START+V_ACTIVE and col < H_ACTIVE.
REQ-021 hsync SHALL be 1 iff HS_START <= col < HS_START+HS_WIDTH, on every line including blanking lines.
REQ-022 vsync SHALL be 1 iff line < VS_LINES, for the whole line duration including hsync.
REQ-023 camData SHALL be (col + (line - V_ACT_START) + frame)[7:0] while href=1, and 0x00 while href=0.
REQ-024 Default timing SHALL give 799,680 pclk cycles per frame, with 480 href pulses of exactly 1280 cycles each.
REQ-025 vsync and href SHALL never both be 1.
REQ-026 The block SHALL have no inputs other than pclk and reset and SHALL free-run indefinitely.

Reset
REQ-027 While reset=0, col, line and frame SHALL be 0 and href, hsync, vsync, camData SHALL be 0, regardless of pclk.
REQ-028 Reset assertion mid-frame SHALL clear state immediately (asynchronously).
REQ-029 After reset deasserts, the first falling edge SHALL produce outputs for col=0, line=0 (vsync=1, href=0), and the frame SHALL restart from line 0.

Verification
REQ-030 Reset held low for 3 cycles -> all outputs 0; first falling edge after release -> vsync=1, href=0, hsync=0.
REQ-031 Defaults, count from a vsync rising edge to the next -> 799,680 cycles; vsync high for 4,704 cycles (3x1568).
REQ-032 Defaults, one frame -> exactly 480 href pulses, each 1280 cycles long; first pulse starts at cycle 20x1568 after the vsync rise.
REQ-033 Defaults, any line -> hsync high for cycles 1312..1471, 160 cycles; href already low by then.
REQ-034 Frame 0, first active line (line 20) -> camData 0x00,0x01,...,0xFF,0x00,...; frame 1 same line starts at 0x01; camData=0 whenever href=0.
REQ-035 Small parameters (H_TOTAL=16, H_ACTIVE=8, HS_START=10, HS_WIDTH=2, V_TOTAL=8, VS_LINES=1, V_ACT_START=2, V_ACTIVE=4), reset asserted at line 5 then released -> outputs clear at once; the next frame starts at line 0 with vsync=1 for 16 cycles.
